// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO with registered storage; extra pointer MSB separates full from empty.
// Head word is read straight from the storage flops, so it holds steady until popped.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, small receive FIFO with valid/ready pop.
// Byte visible on rvalid_o the cycle after the mid-stop sample; a full FIFO without a pop drops the byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q, overrun_q;
  logic          tick, push, pop, fifo_full, fifo_empty;

  assign tick = (timer_q == '0);
  assign push = (state_q == S_STOP) && tick && rx_s_q;
  assign pop  = rready_i && !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (state_q != S_IDLE && state_q != S_BREAK && !tick) timer_q <= timer_q - 1'b1;
      case (state_q)
        S_IDLE: if (!rx_s_q) begin
          timer_q <= HALF_BIT;
          state_q <= S_START;
        end
        S_START: if (tick) begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end else begin
            timer_q   <= FULL_BIT;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: if (tick) begin
          shift_q   <= {rx_s_q, shift_q[7:1]};
          timer_q   <= FULL_BIT;
          bit_idx_q <= bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_q <= S_STOP;
        end
        S_STOP: if (tick) begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= S_BREAK;
          end
        end
        S_BREAK: if (rx_s_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overrun_q <= 1'b0;
    else         overrun_q <= push && fifo_full && !pop;
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rvalid_o    = !fifo_empty;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial driver, byte scoreboard popped on each handshake, pulse counters.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, busy, frame_err, overrun;

  int nchk = 0;
  int nerr = 0;
  logic [7:0] sb [$];
  int fe_cnt = 0, ov_cnt = 0, busy_cyc = 0, vld_cyc = 0, pop_cnt = 0;
  int fe0, ov0, busy0, vld0, pop0;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rxd_i       (rxd),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic expect_it);
    if (expect_it) sb.push_back(b);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; busy0 = busy_cyc; vld0 = vld_cyc; pop0 = pop_cnt;
  endtask

  initial begin
    logic [8:0] exp9;
    fork
      forever begin
        @(negedge clk);
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (busy)      busy_cyc++;
        if (rvalid)    vld_cyc++;
        if (rvalid && rready) begin
          pop_cnt++;
          exp9 = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100;
          check("rdata", {23'd0, 1'b0, rdata}, {23'd0, exp9});
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;

    // Idle line
    snap();
    hold(1'b1, 10000);
    check("idle_busy", busy_cyc - busy0, 0);
    check("idle_vld", vld_cyc - vld0, 0);
    check("idle_fe", fe_cnt - fe0, 0);
    check("idle_ov", ov_cnt - ov0, 0);

    // Back-to-back bytes with consumer ready
    rready = 1'b1;
    snap();
    send(8'h55, 1'b1, 1'b1);
    send(8'hA3, 1'b1, 1'b1);
    hold(1'b1, 40);
    check("b2b_pops", pop_cnt - pop0, 2);
    check("b2b_vld_cycles", vld_cyc - vld0, 2);
    check("b2b_sb_empty", sb.size(), 0);
    check("b2b_fe", fe_cnt - fe0, 0);
    check("b2b_ov", ov_cnt - ov0, 0);

    // Start-bit glitch
    snap();
    hold(1'b0, 6);
    hold(1'b1, 40);
    check("glitch_busy_seen", (busy_cyc - busy0) > 0, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_pops", pop_cnt - pop0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);

    // Framing error followed by break, then a good byte
    snap();
    send(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 2 * CPB);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_no_byte", pop_cnt - pop0, 0);
    send(8'h81, 1'b1, 1'b1);
    hold(1'b1, 40);
    check("ferr_after_pops", pop_cnt - pop0, 1);
    check("ferr_sb_empty", sb.size(), 0);
    check("ferr_total", fe_cnt - fe0, 1);

    // Overrun with consumer stalled
    rready = 1'b0;
    snap();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b1);
    hold(1'b1, 20);
    check("ovr_before", ov_cnt - ov0, 0);
    send(8'h05, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_head_vld", rvalid, 1);
    check("ovr_head_dat", rdata, 8'h01);
    rready = 1'b1;
    hold(1'b1, 20);
    check("ovr_pops", pop_cnt - pop0, 4);
    check("ovr_sb_empty", sb.size(), 0);
    check("ovr_drained", rvalid, 0);

    // Reset in the middle of a frame
    snap();
    hold(1'b0, CPB);
    hold(1'b0, 3 * CPB);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vld", rvalid, 0);
    check("mid_rst_dat", rdata, 0);
    check("mid_rst_fe", frame_err, 0);
    check("mid_rst_ov", overrun, 0);
    hold(1'b1, 5);
    rst_n = 1'b1;
    hold(1'b1, 2 * CPB);
    send(8'h0F, 1'b1, 1'b1);
    hold(1'b1, 40);
    check("mid_pops", pop_cnt - pop0, 1);
    check("mid_sb_empty", sb.size(), 0);
    check("mid_fe", fe_cnt - fe0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
